// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : Shared types, CSR addresses and field constants for csr_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH= 12'hB82;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIP_MSIP     = 3;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    localparam logic [31:0] MSTATUS_WMASK  = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_MPP_RO = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK      = 32'h0000_0888;
    localparam logic [31:0] MTVEC_WMASK    = 32'hFFFF_FFFD;
    localparam logic [31:0] MEPC_WMASK     = 32'hFFFF_FFFC;

endpackage
`default_nettype wire

// File: rtl/csr_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit_if
// Description : CSR access bus between the execute stage and csr_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_unit_if;
    import csr_pkg::*;

    csr_op_e     csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_wsup;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_op, csr_addr, csr_wdata, csr_wsup,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_op, csr_addr, csr_wdata, csr_wsup,
        output csr_rdata, csr_illegal
    );

endinterface
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter64
// Description : 64-bit free-running counter with per-half overwrite.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        inc,
    input  wire logic        wr_lo,
    input  wire logic        wr_hi,
    input  wire logic [31:0] wdata,
    output logic      [63:0] value
);

    logic [63:0] r_value;

    // A half-write replaces the increment for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= 64'd0;
        end else if (wr_lo) begin
            r_value[31:0] <= wdata;
        end else if (wr_hi) begin
            r_value[63:32] <= wdata;
        end else if (inc) begin
            r_value <= r_value + 64'd1;
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit
// Description : RV32 machine-mode CSR file with sparse decode and trap/mret.
//               Define CSR_COUNTERS_EN to implement mcycle/minstret + shadows.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] HARTID      = 32'd0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    csr_unit_if.slave        csr_bus,
    input  wire logic        instr_ret,
    input  wire logic        trap_valid,
    input  wire logic [31:0] trap_cause,
    input  wire logic [31:0] trap_pc,
    input  wire logic [31:0] trap_val,
    input  wire logic        mret,
    input  wire logic        irq_sw,
    input  wire logic        irq_timer,
    input  wire logic        irq_ext,
    output logic      [31:0] mtvec_o,
    output logic      [31:0] mepc_o,
    output logic             irq_pending
);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic [31:0] w_mstatus;
    logic [31:0] w_mip;
    logic [31:0] w_rval;
    logic [31:0] w_new;
    logic        w_impl;
    logic        w_wr_req;
    logic        w_illegal;
    logic        w_we;

`ifdef CSR_COUNTERS_EN
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (w_we && (csr_bus.csr_addr == CSR_MCYCLE)),
        .wr_hi (w_we && (csr_bus.csr_addr == CSR_MCYCLEH)),
        .wdata (w_new),
        .value (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instr_ret),
        .wr_lo (w_we && (csr_bus.csr_addr == CSR_MINSTRET)),
        .wr_hi (w_we && (csr_bus.csr_addr == CSR_MINSTRETH)),
        .wdata (w_new),
        .value (w_minstret)
    );
`else
    logic w_unused_instr_ret;
    assign w_unused_instr_ret = instr_ret;
`endif

    always_comb begin
        w_mstatus                = MSTATUS_MPP_RO;
        w_mstatus[MSTATUS_MIE]   = r_mstatus_mie;
        w_mstatus[MSTATUS_MPIE]  = r_mstatus_mpie;
        w_mip                    = 32'd0;
        w_mip[MIP_MSIP]          = irq_sw;
        w_mip[MIP_MTIP]          = irq_timer;
        w_mip[MIP_MEIP]          = irq_ext;
    end

    always_comb begin
        w_impl = 1'b1;
        w_rval = 32'd0;
        case (csr_bus.csr_addr)
            CSR_MSTATUS:  w_rval = w_mstatus;
            CSR_MISA:     w_rval = MISA_VALUE;
            CSR_MIE:      w_rval = r_mie;
            CSR_MTVEC:    w_rval = r_mtvec;
            CSR_MSCRATCH: w_rval = r_mscratch;
            CSR_MEPC:     w_rval = r_mepc;
            CSR_MCAUSE:   w_rval = r_mcause;
            CSR_MTVAL:    w_rval = r_mtval;
            CSR_MIP:      w_rval = w_mip;
            CSR_MHARTID:  w_rval = HARTID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE,   CSR_CYCLE:    w_rval = w_mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:   w_rval = w_mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:  w_rval = w_minstret[31:0];
            CSR_MINSTRETH,CSR_INSTRETH: w_rval = w_minstret[63:32];
`endif
            default:      w_impl = 1'b0;
        endcase
    end

    // Write intent ignores legality; the read-only address space turns intent into illegal.
    assign w_wr_req  = (csr_bus.csr_op != CSR_OP_NONE)
                     && ((csr_bus.csr_op == CSR_OP_RW) || !csr_bus.csr_wsup)
                     && !trap_valid;
    assign w_illegal = (csr_bus.csr_op != CSR_OP_NONE)
                     && (!w_impl || ((csr_bus.csr_addr[11:10] == 2'b11) && w_wr_req));
    assign w_we      = w_wr_req && !w_illegal;

    always_comb begin
        w_new = csr_bus.csr_wdata;
        case (csr_bus.csr_op)
            CSR_OP_RS: w_new = w_rval | csr_bus.csr_wdata;
            CSR_OP_RC: w_new = w_rval & ~csr_bus.csr_wdata;
            default:   w_new = csr_bus.csr_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'd0;
            r_mtvec        <= MTVEC_RESET & MTVEC_WMASK;
            r_mscratch     <= 32'd0;
            r_mepc         <= 32'd0;
            r_mcause       <= 32'd0;
            r_mtval        <= 32'd0;
        end else if (trap_valid) begin
            r_mepc         <= trap_pc & MEPC_WMASK;
            r_mcause       <= trap_cause;
            r_mtval        <= trap_val;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else begin
            if (mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end
            if (w_we) begin
                case (csr_bus.csr_addr)
                    CSR_MSTATUS: begin
                        // mret owns mstatus this cycle.
                        if (!mret) begin
                            r_mstatus_mie  <= w_new[MSTATUS_MIE];
                            r_mstatus_mpie <= w_new[MSTATUS_MPIE];
                        end
                    end
                    CSR_MIE:      r_mie      <= w_new & MIE_WMASK;
                    CSR_MTVEC:    r_mtvec    <= w_new & MTVEC_WMASK;
                    CSR_MSCRATCH: r_mscratch <= w_new;
                    CSR_MEPC:     r_mepc     <= w_new & MEPC_WMASK;
                    CSR_MCAUSE:   r_mcause   <= w_new;
                    CSR_MTVAL:    r_mtval    <= w_new;
                    default: ;
                endcase
            end
        end
    end

    assign csr_bus.csr_rdata   = ((csr_bus.csr_op != CSR_OP_NONE) && !w_illegal) ? w_rval : 32'd0;
    assign csr_bus.csr_illegal = w_illegal;
    assign mtvec_o             = r_mtvec;
    assign mepc_o              = r_mepc;
    assign irq_pending         = r_mstatus_mie && (|(r_mie & w_mip));

endmodule
`default_nettype wire
